// File: rtl/rpsc_input_conditioner.sv
// ---------------------------------------------------------------------------
// rpsc_input_conditioner
//
// Front-end conditioning stage for the RPSC card logic. Each raw rack line
// (card position, emergency, door/PAMP, PS fault, PS-active, U-low,
// OT-ready, ...) is passed through a 2-FF synchroniser and then a per-channel
// debounce counter. The result is a clean level for the card-2 interlock and
// timer logic. The block also produces per-channel edge strobes and, when
// enabled, a first-fault record for the operator display.
//
// Optional feature macro: RPSC_FIRST_FAULT_EN
//   defined   : first-fault capture (ff_valid / ff_index / ff_ack) is built
//   undefined : ff_valid and ff_index are tied to 0 and ff_ack is ignored
//
// Parameters
//   N_CH        number of conditioned channels (at least 2)
//   DEB_CYCLES  consecutive stable cycles needed to accept a level (1..255)
//   RESET_VAL   filtered level loaded at reset (1 = fault, fail-safe)
//   FAULT_MASK  channels eligible for first-fault capture
//
// Ports
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   raw_in    in   asynchronous raw input lines
//   filt_out  out  debounced levels
//   rise_stb  out  one-cycle pulse when filt_out[k] goes 0->1
//   fall_stb  out  one-cycle pulse when filt_out[k] goes 1->0
//   settled   out  every channel's synced level matches filt_out, counters idle
//   ff_valid  out  first-fault record held
//   ff_index  out  channel number of the first fault
//   ff_ack    in   operator acknowledge, clears the record
// ---------------------------------------------------------------------------
module rpsc_input_conditioner #(
    parameter int              N_CH       = 20,
    parameter int              DEB_CYCLES = 8,
    parameter logic [N_CH-1:0] RESET_VAL  = {N_CH{1'b1}},
    parameter logic [N_CH-1:0] FAULT_MASK = {N_CH{1'b1}}
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CH-1:0]         raw_in,
    output logic [N_CH-1:0]         filt_out,
    output logic [N_CH-1:0]         rise_stb,
    output logic [N_CH-1:0]         fall_stb,
    output logic                    settled,
    output logic                    ff_valid,
    output logic [$clog2(N_CH)-1:0] ff_index,
    input  logic                    ff_ack
);

    localparam int             CW       = $clog2(DEB_CYCLES + 1);
    localparam int             IW       = $clog2(N_CH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [N_CH-1:0] s1_q,   s1_d;
    logic [N_CH-1:0] s2_q,   s2_d;
    logic [N_CH-1:0] filt_q, filt_d;
    logic [N_CH-1:0] rise_q, rise_d;
    logic [N_CH-1:0] fall_q, fall_d;
    logic [CW-1:0]   cnt_q [N_CH];
    logic [CW-1:0]   cnt_d [N_CH];
    logic [N_CH-1:0] chan_settled;

    // Synchroniser and debounce next-state. A channel whose synced level
    // matches its filtered level always drops its count, so a single sample
    // back at the old level throws away any progress made so far.
    always_comb begin
        s1_d         = raw_in;
        s2_d         = s1_q;
        filt_d       = filt_q;
        rise_d       = '0;
        fall_d       = '0;
        chan_settled = '0;
        for (int k = 0; k < N_CH; k++) begin
            cnt_d[k] = cnt_q[k];
            if (s2_q[k] == filt_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == CNT_LAST) begin
                // Strobes are registered alongside filt so they appear in
                // the same cycle the new level becomes visible.
                cnt_d[k]  = '0;
                filt_d[k] = s2_q[k];
                rise_d[k] = s2_q[k];
                fall_d[k] = ~s2_q[k];
            end else begin
                cnt_d[k] = cnt_q[k] + CW'(1);
            end
            chan_settled[k] = (s2_q[k] == filt_q[k]) && (cnt_q[k] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q   <= RESET_VAL;
            s2_q   <= RESET_VAL;
            filt_q <= RESET_VAL;
            rise_q <= '0;
            fall_q <= '0;
            for (int k = 0; k < N_CH; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            filt_q <= filt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int k = 0; k < N_CH; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign filt_out = filt_q;
    assign rise_stb = rise_q;
    assign fall_stb = fall_q;
    assign settled  = &chan_settled;

`ifdef RPSC_FIRST_FAULT_EN
    logic            ff_valid_q, ff_valid_d;
    logic [IW-1:0]   ff_index_q, ff_index_d;
    logic [N_CH-1:0] ff_qual;
    logic [IW-1:0]   ff_low;

    // Capture the lowest-numbered eligible rise. An acknowledge arriving
    // together with a new rise retires the old record and takes the new one.
    always_comb begin
        ff_qual = rise_q & FAULT_MASK;
        ff_low  = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (ff_qual[k]) begin
                ff_low = IW'(k);
            end
        end
        ff_valid_d = ff_valid_q;
        ff_index_d = ff_index_q;
        if ((|ff_qual) && (!ff_valid_q || ff_ack)) begin
            ff_valid_d = 1'b1;
            ff_index_d = ff_low;
        end else if (ff_ack) begin
            ff_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ff_valid_q <= 1'b0;
            ff_index_q <= '0;
        end else begin
            ff_valid_q <= ff_valid_d;
            ff_index_q <= ff_index_d;
        end
    end

    assign ff_valid = ff_valid_q;
    assign ff_index = ff_index_q;
`else
    // Capture disabled: the acknowledge and mask are deliberately unused.
    logic ff_unused;
    assign ff_unused = ff_ack ^ (^FAULT_MASK);
    assign ff_valid  = 1'b0;
    assign ff_index  = '0;
`endif

endmodule

// File: tb/tb_rpsc_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_rpsc_input_conditioner
//
// Self-checking bench for rpsc_input_conditioner. Directed scenarios check
// the documented behaviours against fixed expectations; a randomized run is
// checked cycle by cycle against a reference model that works from the raw
// sample history: a level is accepted once the last DEB synchronised samples
// all agree on a value different from the current filtered level.
// Build with RPSC_FIRST_FAULT_EN defined to exercise first-fault capture.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rpsc_input_conditioner;

    localparam int            N   = 20;
    localparam int            DEB = 8;
    localparam int            IW  = $clog2(N);
    localparam int            HL  = DEB + 2;
    localparam logic [N-1:0]  RV  = {N{1'b1}};
    localparam logic [N-1:0]  MSK = {N{1'b1}};

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  raw_in;
    logic [N-1:0]  filt_out;
    logic [N-1:0]  rise_stb;
    logic [N-1:0]  fall_stb;
    logic          settled;
    logic          ff_valid;
    logic [IW-1:0] ff_index;
    logic          ff_ack;

    int total = 0;
    int bad   = 0;

    rpsc_input_conditioner #(
        .N_CH       (N),
        .DEB_CYCLES (DEB),
        .RESET_VAL  (RV),
        .FAULT_MASK (MSK)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .raw_in   (raw_in),
        .filt_out (filt_out),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb),
        .settled  (settled),
        .ff_valid (ff_valid),
        .ff_index (ff_index),
        .ff_ack   (ff_ack)
    );

    always #5 clk = ~clk;

    // Reference model, updated on each rising edge from the sampled inputs.
    // rh[i] holds the raw value sampled i edges ago; the synchronised level
    // seen by the debouncer at this edge is therefore rh[2].
    logic [N-1:0]  rh [HL];
    logic [N-1:0]  m_filt, m_rise, m_fall;
    logic          m_settled;
    logic          m_ffv;
    logic [IW-1:0] m_ffi;

    always @(posedge clk) begin
        logic [N-1:0] q;
        logic         v, same;
        q = m_rise & MSK;
`ifdef RPSC_FIRST_FAULT_EN
        if (!reset) begin
            if (q != '0 && (!m_ffv || ff_ack)) begin
                m_ffv = 1'b1;
                for (int k = N - 1; k >= 0; k--) if (q[k]) m_ffi = IW'(k);
            end else if (ff_ack) begin
                m_ffv = 1'b0;
            end
        end
`endif
        if (reset) begin
            for (int i = 0; i < HL; i++) rh[i] = RV;
            m_filt = RV;
            m_rise = '0;
            m_fall = '0;
            m_ffv  = 1'b0;
            m_ffi  = '0;
        end else begin
            for (int i = HL - 1; i > 0; i--) rh[i] = rh[i-1];
            rh[0]  = raw_in;
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < N; c++) begin
                v    = rh[2][c];
                same = 1'b1;
                for (int j = 2; j < HL; j++) if (rh[j][c] != v) same = 1'b0;
                if (same && v != m_filt[c]) begin
                    m_filt[c] = v;
                    if (v) m_rise[c] = 1'b1;
                    else   m_fall[c] = 1'b1;
                end
            end
        end
        m_settled = 1'b1;
        for (int c = 0; c < N; c++)
            if (rh[1][c] != m_filt[c] || rh[2][c] != m_filt[c]) m_settled = 1'b0;
    end

    task automatic test_reset;
        logic [N-1:0] ef, efall;
        reset  = 1'b1;
        raw_in = '0;
        ff_ack = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (filt_out !== RV || rise_stb !== '0 || fall_stb !== '0 ||
            ff_valid !== 1'b0 || ff_index !== '0)
            begin bad++; $display("[TB] FAIL reset_state filt=%h rise=%h fall=%h ffv=%b ffi=%0d want filt=%h others 0",
                                  filt_out, rise_stb, fall_stb, ff_valid, ff_index, RV); end
        reset = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk);
            ef    = (e >= 10) ? '0 : RV;
            efall = (e == 10) ? RV : '0;
            total++;
            if (filt_out !== ef)
                begin bad++; $display("[TB] FAIL reset_release_filt edge=%0d got=%h want=%h", e, filt_out, ef); end
            total++;
            if (fall_stb !== efall || rise_stb !== '0)
                begin bad++; $display("[TB] FAIL reset_release_stb edge=%0d fall=%h rise=%h want fall=%h rise=0", e, fall_stb, rise_stb, efall); end
            if (e >= 2) begin
                total++;
                if (settled !== (e >= 10))
                    begin bad++; $display("[TB] FAIL reset_release_settled edge=%0d got=%b want=%b", e, settled, (e >= 10)); end
            end
        end
    endtask

    task automatic test_single_rise;
        logic [N-1:0] ef, er;
        raw_in[3] = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk);
            ef = '0; ef[3] = (e >= 10);
            er = '0; er[3] = (e == 10);
            total++;
            if (filt_out !== ef)
                begin bad++; $display("[TB] FAIL single_rise_filt edge=%0d got=%h want=%h", e, filt_out, ef); end
            total++;
            if (rise_stb !== er || fall_stb !== '0)
                begin bad++; $display("[TB] FAIL single_rise_stb edge=%0d rise=%h fall=%h want rise=%h fall=0", e, rise_stb, fall_stb, er); end
        end
    endtask

    task automatic test_short_pulse(input int len);
        int  rises = 0, falls = 0;
        bit  seen_high = 0;
        int  want = (len >= DEB) ? 1 : 0;
        for (int c = 0; c < 24; c++) begin
            raw_in[5] = (c < len);
            @(negedge clk);
            if (rise_stb[5]) rises++;
            if (fall_stb[5]) falls++;
            if (filt_out[5]) seen_high = 1;
        end
        total++;
        if (rises != want || falls != want)
            begin bad++; $display("[TB] FAIL short_pulse_%0d rises=%0d falls=%0d want=%0d each", len, rises, falls, want); end
        total++;
        if (seen_high != (len >= DEB))
            begin bad++; $display("[TB] FAIL short_pulse_level_%0d seen_high=%0d want=%0d", len, seen_high, want); end
        total++;
        if (filt_out[5] !== 1'b0)
            begin bad++; $display("[TB] FAIL short_pulse_end_%0d got=%b want=0", len, filt_out[5]); end
    endtask

    task automatic test_chatter;
        for (int c = 0; c < 50; c++) begin
            raw_in[4] = ((c % 7) < 6);
            @(negedge clk);
            total++;
            if (filt_out[4] !== 1'b0 || rise_stb[4] !== 1'b0 || fall_stb[4] !== 1'b0)
                begin bad++; $display("[TB] FAIL chatter cycle=%0d filt=%b rise=%b fall=%b want all 0", c, filt_out[4], rise_stb[4], fall_stb[4]); end
        end
        raw_in[4] = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic [N-1:0] ef;
        raw_in = '1;
        repeat (14) @(negedge clk);
        raw_in[6] = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (filt_out !== RV || rise_stb !== '0 || fall_stb !== '0)
            begin bad++; $display("[TB] FAIL reset_mid_state filt=%h rise=%h fall=%h want filt=%h", filt_out, rise_stb, fall_stb, RV); end
        reset = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk);
            ef = RV; ef[6] = (e < 10);
            total++;
            if (filt_out !== ef)
                begin bad++; $display("[TB] FAIL reset_mid_filt edge=%0d got=%h want=%h", e, filt_out, ef); end
        end
    endtask

`ifdef RPSC_FIRST_FAULT_EN
    task automatic test_first_fault;
        raw_in = '0;
        repeat (12) @(negedge clk);
        ff_ack = 1'b1;
        @(negedge clk);
        ff_ack = 1'b0;
        total++;
        if (ff_valid !== 1'b0)
            begin bad++; $display("[TB] FAIL ff_clear_start got=%b want=0", ff_valid); end
        raw_in[7] = 1'b1;
        raw_in[2] = 1'b1;
        repeat (11) @(negedge clk);
        total++;
        if (ff_valid !== 1'b1 || ff_index !== IW'(2))
            begin bad++; $display("[TB] FAIL ff_lowest valid=%b index=%0d want 1/2", ff_valid, ff_index); end
        raw_in[1] = 1'b1;
        repeat (12) @(negedge clk);
        total++;
        if (ff_valid !== 1'b1 || ff_index !== IW'(2))
            begin bad++; $display("[TB] FAIL ff_hold valid=%b index=%0d want 1/2", ff_valid, ff_index); end
        ff_ack = 1'b1;
        @(negedge clk);
        ff_ack = 1'b0;
        total++;
        if (ff_valid !== 1'b0)
            begin bad++; $display("[TB] FAIL ff_ack got=%b want=0", ff_valid); end
        ff_ack = 1'b1;
        @(negedge clk);
        ff_ack = 1'b0;
        total++;
        if (ff_valid !== 1'b0)
            begin bad++; $display("[TB] FAIL ff_ack_noop got=%b want=0", ff_valid); end
    endtask

    task automatic test_ack_with_rise;
        raw_in[8] = 1'b1;
        repeat (11) @(negedge clk);
        total++;
        if (ff_valid !== 1'b1 || ff_index !== IW'(8))
            begin bad++; $display("[TB] FAIL ff_capture8 valid=%b index=%0d want 1/8", ff_valid, ff_index); end
        raw_in[9] = 1'b1;
        repeat (10) @(negedge clk);
        total++;
        if (rise_stb[9] !== 1'b1)
            begin bad++; $display("[TB] FAIL ff_rise9 got=%b want=1", rise_stb[9]); end
        ff_ack = 1'b1;
        @(negedge clk);
        ff_ack = 1'b0;
        total++;
        if (ff_valid !== 1'b1 || ff_index !== IW'(9))
            begin bad++; $display("[TB] FAIL ff_ack_rise valid=%b index=%0d want 1/9", ff_valid, ff_index); end
    endtask
`else
    task automatic test_ff_tied;
        raw_in = '0;
        for (int c = 0; c < 30; c++) begin
            ff_ack = c[0];
            if (c == 2) raw_in[0] = 1'b1;
            @(negedge clk);
            total++;
            if (ff_valid !== 1'b0 || ff_index !== '0)
                begin bad++; $display("[TB] FAIL ff_tied cycle=%0d valid=%b index=%0d want 0/0", c, ff_valid, ff_index); end
        end
        ff_ack = 1'b0;
    endtask
`endif

    task automatic test_random;
        int hold [N];
        for (int c = 0; c < N; c++) hold[c] = $urandom_range(1, 12);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < N; c++) begin
                hold[c]--;
                if (hold[c] <= 0) begin
                    raw_in[c] = ~raw_in[c];
                    hold[c]   = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 40)
                                                            : $urandom_range(1, 12);
                end
            end
            reset  = ($urandom_range(0, 499) == 0);
            ff_ack = ($urandom_range(0, 19) == 0);
            @(negedge clk);
            total++;
            if (filt_out !== m_filt)
                begin bad++; $display("[TB] FAIL rand_filt cycle=%0d got=%h want=%h", cyc, filt_out, m_filt); end
            total++;
            if (rise_stb !== m_rise || fall_stb !== m_fall)
                begin bad++; $display("[TB] FAIL rand_stb cycle=%0d rise=%h fall=%h want rise=%h fall=%h", cyc, rise_stb, fall_stb, m_rise, m_fall); end
            total++;
            if (settled !== m_settled)
                begin bad++; $display("[TB] FAIL rand_settled cycle=%0d got=%b want=%b", cyc, settled, m_settled); end
            total++;
            if (ff_valid !== m_ffv || (m_ffv && ff_index !== m_ffi))
                begin bad++; $display("[TB] FAIL rand_ff cycle=%0d valid=%b index=%0d want %b/%0d", cyc, ff_valid, ff_index, m_ffv, m_ffi); end
        end
        reset  = 1'b0;
        ff_ack = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        raw_in = '0;
        ff_ack = 1'b0;
        test_reset();
        test_single_rise();
        test_short_pulse(7);
        test_short_pulse(8);
        test_chatter();
`ifdef RPSC_FIRST_FAULT_EN
        test_first_fault();
        test_ack_with_rise();
`else
        test_ff_tied();
`endif
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

endmodule
